dpram_be_pipelined: RTL and testbench

//  Single-clock dual-port RAM: one write port with byte enables, one read port.

---
 rtl/dpram_be_pipelined.sv | 185 ++++++++++++++++++
 tb/tb_dpram_be_pipelined.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_pipelined.sv
// dpram_be_pipelined: single-clock RAM with one byte-masked write port and
// one registered read port (1 or 2 cycle latency), optional same-address
// read-during-write forwarding and an optional post-reset zero sweep.
module dpram_be_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic                               init_busy,
    input  logic [ADDRESS_WIDTH-1:0]           write_address,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   write_byte_enable,
    input  logic                               write_enable,
    input  logic [ADDRESS_WIDTH-1:0]           read_address,
    input  logic                               read_enable,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 1 << ADDRESS_WIDTH;
    // Counter value of the last word swept; one extra bit so DEPTH is representable.
    localparam logic [ADDRESS_WIDTH:0] CLR_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Replace the enabled byte lanes of old_word with the matching lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  lane_en
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lane_en[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return merged;
    endfunction

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                     init_busy_q, init_busy_d;

    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic                     mem_we_s;
    logic [ADDRESS_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0]    mem_wdata_s;
    logic [NUM_BYTES-1:0]     mem_be_s;

    logic                     rd_fire_s;
    logic                     collision_s;
    logic [DATA_WIDTH-1:0]    rd_old_s;
    logic [DATA_WIDTH-1:0]    rd_word_s;

    logic                     s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]    s1_data_q, s1_data_d;
    logic                     read_valid_q, read_valid_d;
    logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;

    // Next state of the clear sweep; READY is terminal until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + (ADDRESS_WIDTH + 1)'(1);
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
        init_busy_d = (state_d == ST_CLEAR);
    end

    // Array write port: the clear sweep takes priority over user writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = write_address;
        mem_wdata_s = write_data;
        mem_be_s    = write_byte_enable;
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_q[ADDRESS_WIDTH-1:0];
            mem_wdata_s = {DATA_WIDTH{1'b0}};
            mem_be_s    = {NUM_BYTES{1'b1}};
        end else begin
            mem_we_s = write_enable;
        end
    end

    // Read word selection, including same-address forwarding of the merged write.
    always_comb begin
        rd_fire_s   = read_enable && (state_q == ST_READY);
        rd_old_s    = mem_q[read_address];
        collision_s = write_enable && (state_q == ST_READY) && (write_address == read_address);
        if ((BYPASS != 0) && collision_s) begin
            rd_word_s = merge_lanes(rd_old_s, write_data, write_byte_enable);
        end else begin
            rd_word_s = rd_old_s;
        end
    end

    // Read pipeline: stage 1 is only observed when two cycles of latency are chosen.
    always_comb begin
        s1_valid_d = rd_fire_s;
        if (rd_fire_s) begin
            s1_data_d = rd_word_s;
        end else begin
            s1_data_d = s1_data_q;
        end
        if (READ_LATENCY == 2) begin
            read_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                read_data_d = s1_data_q;
            end else begin
                read_data_d = read_data_q;
            end
        end else begin
            read_valid_d = rd_fire_s;
            if (rd_fire_s) begin
                read_data_d = rd_word_s;
            end else begin
                read_data_d = read_data_q;
            end
        end
    end

    // Byte-lane masked storage update; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_be_s[i]) begin
                    mem_q[mem_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Control and read-pipeline registers with synchronous reset that flushes in-flight reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt_q    <= {(ADDRESS_WIDTH + 1){1'b0}};
            init_busy_q  <= (CLEAR_ON_RESET != 0);
            s1_valid_q   <= 1'b0;
            s1_data_q    <= {DATA_WIDTH{1'b0}};
            read_valid_q <= 1'b0;
            read_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            init_busy_q  <= init_busy_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            read_valid_q <= read_valid_d;
            read_data_q  <= read_data_d;
        end
    end

    assign init_busy  = init_busy_q;
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

endmodule

// File: tb/tb_dpram_be_pipelined.sv
// Directed bench for dpram_be_pipelined: two instances share all inputs.
// Instance A: READ_LATENCY=1, BYPASS=1.  Instance B: READ_LATENCY=2, BYPASS=0.
module tb_dpram_be_pipelined;

    logic        clock;
    logic        reset;
    logic [3:0]  write_address;
    logic [31:0] write_data;
    logic [3:0]  write_byte_enable;
    logic        write_enable;
    logic [3:0]  read_address;
    logic        read_enable;

    logic        busy_a, rv_a, busy_b, rv_b;
    logic [31:0] rd_a, rd_b;

    int n_checks = 0;
    int n_fail   = 0;

    dpram_be_pipelined #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clock(clock), .reset(reset), .init_busy(busy_a),
        .write_address(write_address), .write_data(write_data),
        .write_byte_enable(write_byte_enable), .write_enable(write_enable),
        .read_address(read_address), .read_enable(read_enable),
        .read_data(rd_a), .read_valid(rv_a)
    );

    dpram_be_pipelined #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clock(clock), .reset(reset), .init_busy(busy_b),
        .write_address(write_address), .write_data(write_data),
        .write_byte_enable(write_byte_enable), .write_enable(write_enable),
        .read_address(read_address), .read_enable(read_enable),
        .read_data(rd_b), .read_valid(rv_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        a_v;
        logic [31:0] a_d;
        logic        b_v;
        logic [31:0] b_d;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic [3:0] be, input logic re, input logic [3:0] ra,
                                input logic a_v, input logic [31:0] a_d,
                                input logic b_v, input logic [31:0] b_d);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.be = be; v.re = re; v.ra = ra;
        v.a_v = a_v; v.a_d = a_d; v.b_v = b_v; v.b_d = b_d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic av, input logic [31:0] ad,
                              input logic bv, input logic [31:0] bd);
        check({tag, "_a_valid"}, {31'b0, rv_a}, {31'b0, av});
        check({tag, "_a_data"},  rd_a, ad);
        check({tag, "_b_valid"}, {31'b0, rv_b}, {31'b0, bv});
        check({tag, "_b_data"},  rd_b, bd);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        // Stimulus table: one row per edge; expectations are after that edge.
        vecs[0]  = mk(1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 1'b0, 4'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000);
        vecs[1]  = mk(1'b1, 4'd3,  32'h11223344, 4'h5, 1'b0, 4'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000);
        vecs[2]  = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd3,  1'b1, 32'hAA22CC44, 1'b0, 32'h00000000);
        vecs[3]  = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'hAA22CC44, 1'b1, 32'hAA22CC44);
        vecs[4]  = mk(1'b1, 4'd5,  32'hFFFFFFFF, 4'h3, 1'b1, 4'd5,  1'b1, 32'h0000FFFF, 1'b0, 32'hAA22CC44);
        vecs[5]  = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'h0000FFFF, 1'b1, 32'h00000000);
        vecs[6]  = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd5,  1'b1, 32'h0000FFFF, 1'b0, 32'h00000000);
        vecs[7]  = mk(1'b1, 4'd0,  32'h01010101, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0000FFFF, 1'b1, 32'h0000FFFF);
        vecs[8]  = mk(1'b1, 4'd1,  32'h02020202, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0000FFFF, 1'b0, 32'h0000FFFF);
        vecs[9]  = mk(1'b1, 4'd2,  32'h03030303, 4'hF, 1'b1, 4'd0,  1'b1, 32'h01010101, 1'b0, 32'h0000FFFF);
        vecs[10] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd1,  1'b1, 32'h02020202, 1'b1, 32'h01010101);
        vecs[11] = mk(1'b1, 4'd1,  32'h00000000, 4'hF, 1'b1, 4'd2,  1'b1, 32'h03030303, 1'b1, 32'h02020202);
        vecs[12] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'h03030303, 1'b1, 32'h03030303);
        vecs[13] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd1,  1'b1, 32'h00000000, 1'b0, 32'h03030303);
        vecs[14] = mk(1'b1, 4'd3,  32'hDEADBEEF, 4'h0, 1'b1, 4'd3,  1'b1, 32'hAA22CC44, 1'b1, 32'h00000000);
        vecs[15] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'hAA22CC44, 1'b1, 32'hAA22CC44);
        vecs[16] = mk(1'b1, 4'd15, 32'hCAFEF00D, 4'h9, 1'b0, 4'd0,  1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44);
        vecs[17] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd15, 1'b1, 32'hCA00000D, 1'b0, 32'hAA22CC44);
        vecs[18] = mk(1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'hCA00000D, 1'b1, 32'hCA00000D);

        reset = 1'b1; write_enable = 1'b0; write_address = 4'd0; write_data = 32'h0;
        write_byte_enable = 4'h0; read_enable = 1'b0; read_address = 4'd0;

        // Reset state.
        step();
        reset = 1'b0;
        check("rst_busy_a", {31'b0, busy_a}, 32'd1);
        check("rst_busy_b", {31'b0, busy_b}, 32'd1);
        check_outs("rst", 1'b0, 32'h0, 1'b0, 32'h0);

        // Clear sweep: busy for exactly 16 cycles, reads requested meanwhile are ignored.
        read_enable = 1'b1;
        read_address = 4'd7;
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("clr%0d_busy_a", k), {31'b0, busy_a}, {31'b0, (k < 16)});
            check($sformatf("clr%0d_busy_b", k), {31'b0, busy_b}, {31'b0, (k < 16)});
            check($sformatf("clr%0d_rv_a", k), {31'b0, rv_a}, 32'd0);
            check($sformatf("clr%0d_rv_b", k), {31'b0, rv_b}, 32'd0);
        end

        // Every address reads zero, one strobe per read.
        for (int i = 0; i < 16; i++) begin
            read_enable = 1'b1;
            read_address = 4'(i);
            step();
            check_outs($sformatf("zero%0d", i), 1'b1, 32'h0, (i > 0), 32'h0);
        end
        read_enable = 1'b0;
        step();
        check_outs("zero_tail1", 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        check_outs("zero_tail2", 1'b0, 32'h0, 1'b0, 32'h0);

        // Table-driven writes, reads, collisions and pipelined bursts.
        for (int r = 0; r < 19; r++) begin
            write_enable = vecs[r].we; write_address = vecs[r].wa; write_data = vecs[r].wd;
            write_byte_enable = vecs[r].be; read_enable = vecs[r].re; read_address = vecs[r].ra;
            step();
            check_outs($sformatf("vec%0d", r), vecs[r].a_v, vecs[r].a_d, vecs[r].b_v, vecs[r].b_d);
        end
        write_enable = 1'b0; write_byte_enable = 4'h0; read_enable = 1'b0;

        // Reset with reads in flight: issue one read, then reset on the next read edge.
        read_enable = 1'b1; read_address = 4'd0;
        step();
        check_outs("flush_pre", 1'b1, 32'h01010101, 1'b0, 32'hCA00000D);
        read_address = 4'd2; reset = 1'b1;
        step();
        reset = 1'b0; read_enable = 1'b0;
        check_outs("flush_rst", 1'b0, 32'h0, 1'b0, 32'h0);

        // Partial clear, then reset at clear cycle 7; no strobes meanwhile.
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("part%0d_busy_b", k), {31'b0, busy_b}, 32'd1);
            check_outs($sformatf("part%0d", k), 1'b0, 32'h0, 1'b0, 32'h0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("restart_busy_a", {31'b0, busy_a}, 32'd1);

        // Restarted clear with a write to addr 2 that must be ignored.
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            write_enable = (k <= 3);
            write_address = 4'd2; write_data = 32'hFFFFFFFF; write_byte_enable = 4'hF;
            step();
            n = k;
            if (!busy_a) break;
        end
        write_enable = 1'b0; write_byte_enable = 4'h0;
        check("restart_busy_len", n, 32'd16);
        check("restart_busy_b", {31'b0, busy_b}, 32'd0);

        // Post-clear reads: ignored write, previously written words all zero.
        read_enable = 1'b1; read_address = 4'd2;
        step();
        check_outs("post_a2", 1'b1, 32'h0, 1'b0, 32'h0);
        read_address = 4'd0;
        step();
        check_outs("post_a0", 1'b1, 32'h0, 1'b1, 32'h0);
        read_address = 4'd15;
        step();
        check_outs("post_a15", 1'b1, 32'h0, 1'b1, 32'h0);
        read_enable = 1'b0;
        step();
        check_outs("post_tail", 1'b0, 32'h0, 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
